// File: rtl/dump_pkg.sv
// Shared section codes, FSM states and record field widths for the state dump engine.
package dump_pkg;

    localparam int unsigned IDX_W = 16;
    localparam int unsigned SEC_W = 2;

    localparam logic [SEC_W-1:0] SEC_HDR = 2'd0;
    localparam logic [SEC_W-1:0] SEC_GPR = 2'd1;
    localparam logic [SEC_W-1:0] SEC_FPR = 2'd2;
    localparam logic [SEC_W-1:0] SEC_MEM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_HDR,
        ST_GPR,
        ST_FPR,
        ST_MEM_ADDR,
        ST_MEM_CAP,
        ST_FIN
    } dump_state_e;

endpackage

// File: rtl/dump_out_reg.sv
// Record holding register: loads when empty or draining, holds all fields while stalled.
import dump_pkg::*;

module dump_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic              ld_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEC_W-1:0]  out_sec,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              free_c
);

    assign free_c = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load && free_c) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_sec   <= ld_sec;
            out_idx   <= ld_idx;
            out_last  <= ld_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/state_dump_unit.sv
// Architectural-state dump engine: halts the core, streams header, GPRs, FPRs (only when
// DUMP_FPR_EN is defined) and a data-memory window as tagged valid/ready records.
import dump_pkg::*;

module state_dump_unit #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_GPR        = 32,
`ifdef DUMP_FPR_EN
    parameter int unsigned NUM_FPR        = 32,
`endif
    parameter int unsigned RF_AW          = 5,
    parameter int unsigned MEM_AW         = 8,
    parameter int unsigned MEM_BASE       = 0,
    parameter int unsigned MEM_DUMP_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic              rf_sel,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sec,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [RF_AW-1:0]  GPR_LAST  = RF_AW'(NUM_GPR - 1);
`ifdef DUMP_FPR_EN
    localparam logic [RF_AW-1:0]  FPR_LAST  = RF_AW'(NUM_FPR - 1);
`endif
    localparam logic [IDX_W-1:0]  MEM_LAST  = IDX_W'(MEM_DUMP_WORDS - 1);
    localparam logic [MEM_AW-1:0] MEM_FIRST = MEM_AW'(MEM_BASE);

    dump_state_e       state;
    logic [DATA_W-1:0] cyc_cnt;
    logic [DATA_W-1:0] hdr_q;
    logic [IDX_W-1:0]  mem_i;

    logic              load_c;
    logic [DATA_W-1:0] ld_data;
    logic [SEC_W-1:0]  ld_sec;
    logic [IDX_W-1:0]  ld_idx;
    logic              ld_last;
    logic              free_c;

    // Record source select: the state decides what goes into the output register when it frees.
    always_comb begin
        load_c  = 1'b0;
        ld_data = '0;
        ld_sec  = SEC_HDR;
        ld_idx  = '0;
        ld_last = 1'b0;
        if (free_c) begin
            case (state)
                ST_HDR: begin
                    load_c  = 1'b1;
                    ld_data = hdr_q;
                end
                ST_GPR: begin
                    load_c  = 1'b1;
                    ld_data = rf_rdata;
                    ld_sec  = SEC_GPR;
                    ld_idx  = IDX_W'(rf_raddr);
                end
                ST_FPR: begin
                    load_c  = 1'b1;
                    ld_data = rf_rdata;
                    ld_sec  = SEC_FPR;
                    ld_idx  = IDX_W'(rf_raddr);
                end
                ST_MEM_CAP: begin
                    load_c  = 1'b1;
                    ld_data = mem_rdata;
                    ld_sec  = SEC_MEM;
                    ld_idx  = mem_i;
                    ld_last = (mem_i == MEM_LAST);
                end
                default: load_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            hdr_q     <= '0;
            mem_i     <= '0;
            halt_req  <= 1'b0;
            rf_sel    <= 1'b0;
            rf_raddr  <= '0;
            mem_raddr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + DATA_W'(1);
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hdr_q    <= cyc_cnt;
                        busy     <= 1'b1;
                        halt_req <= 1'b1;
                        state    <= ST_HALT_WAIT;
                    end
                end
                ST_HALT_WAIT: begin
                    if (halt_ack) state <= ST_HDR;
                end
                ST_HDR: begin
                    if (load_c) begin
                        rf_sel   <= 1'b0;
                        rf_raddr <= '0;
                        state    <= ST_GPR;
                    end
                end
                ST_GPR: begin
                    if (load_c) begin
                        if (rf_raddr == GPR_LAST) begin
                            rf_raddr <= '0;
`ifdef DUMP_FPR_EN
                            rf_sel   <= 1'b1;
                            state    <= ST_FPR;
`else
                            mem_raddr <= MEM_FIRST;
                            mem_i     <= '0;
                            state     <= ST_MEM_ADDR;
`endif
                        end else begin
                            rf_raddr <= rf_raddr + RF_AW'(1);
                        end
                    end
                end
`ifdef DUMP_FPR_EN
                ST_FPR: begin
                    if (load_c) begin
                        if (rf_raddr == FPR_LAST) begin
                            rf_raddr  <= '0;
                            rf_sel    <= 1'b0;
                            mem_raddr <= MEM_FIRST;
                            mem_i     <= '0;
                            state     <= ST_MEM_ADDR;
                        end else begin
                            rf_raddr <= rf_raddr + RF_AW'(1);
                        end
                    end
                end
`endif
                // Address cycle; memory answers in the following MEM_CAP cycle.
                ST_MEM_ADDR: state <= ST_MEM_CAP;
                ST_MEM_CAP: begin
                    if (load_c) begin
                        if (ld_last) begin
                            state <= ST_FIN;
                        end else begin
                            mem_raddr <= mem_raddr + MEM_AW'(1);
                            mem_i     <= mem_i + IDX_W'(1);
                            state     <= ST_MEM_ADDR;
                        end
                    end
                end
                ST_FIN: begin
                    if (out_valid && out_ready) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        halt_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dump_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .ld_data   (ld_data),
        .ld_sec    (ld_sec),
        .ld_idx    (ld_idx),
        .ld_last   (ld_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sec   (out_sec),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .free_c    (free_c)
    );

endmodule

// File: tb/tb_state_dump_unit.sv
// Scoreboard bench for state_dump_unit; expected records come from the register/memory images.
module tb_state_dump_unit;

    localparam int NUM_GPR = 32;
    localparam int NUM_FPR = 32;
    localparam int WORDS   = 32;
`ifdef DUMP_FPR_EN
    localparam int TOTAL   = 1 + NUM_GPR + NUM_FPR + WORDS;
`else
    localparam int TOTAL   = 1 + NUM_GPR + WORDS;
`endif
    localparam int W_TOTAL = TOTAL - WORDS + 4;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sec;
        logic [15:0] idx;
        logic        last;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start_w = 1'b0;
    logic halt_ack = 1'b0;
    logic out_ready = 1'b0;

    logic        halt_req, rf_sel, out_valid, out_last, busy, done;
    logic [4:0]  rf_raddr;
    logic [7:0]  mem_raddr;
    logic [31:0] rf_rdata, mem_rdata, out_data;
    logic [1:0]  out_sec;
    logic [15:0] out_idx;

    logic        w_halt_req, w_rf_sel, w_out_valid, w_out_last, w_busy, w_done;
    logic [4:0]  w_rf_raddr;
    logic [3:0]  w_mem_raddr;
    logic [31:0] w_rf_rdata, w_mem_rdata, w_out_data;
    logic [1:0]  w_out_sec;
    logic [15:0] w_out_idx;

    logic [31:0] gpr [NUM_GPR];
    logic [31:0] fpr [NUM_FPR];
    logic [31:0] mem [256];
    logic [31:0] wmem [16];
    logic [31:0] tb_cnt = 32'd0;

    rec_t sb[$];
    int errors = 0, checks = 0;
    int n_done = 0, rec_n = 0;
    int w_recs = 0, w_memk = 0;

    always #5 clk = ~clk;

    // Environment: combinational register file, one-cycle-latency memories, reference cycle count.
    assign rf_rdata   = rf_sel ? fpr[rf_raddr] : gpr[rf_raddr];
    assign w_rf_rdata = w_rf_sel ? fpr[w_rf_raddr] : gpr[w_rf_raddr];
    always @(posedge clk) begin
        mem_rdata   <= mem[mem_raddr];
        w_mem_rdata <= wmem[w_mem_raddr];
        tb_cnt      <= rst ? 32'd0 : tb_cnt + 32'd1;
    end

    state_dump_unit dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_sel(rf_sel), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sec(out_sec), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    state_dump_unit #(.MEM_AW(4), .MEM_BASE(14), .MEM_DUMP_WORDS(4)) u_wrap (
        .clk(clk), .rst(rst), .start(start_w), .halt_req(w_halt_req), .halt_ack(1'b1),
        .rf_sel(w_rf_sel), .rf_raddr(w_rf_raddr), .rf_rdata(w_rf_rdata),
        .mem_raddr(w_mem_raddr), .mem_rdata(w_mem_rdata),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
        .out_sec(w_out_sec), .out_idx(w_out_idx), .out_last(w_out_last),
        .busy(w_busy), .done(w_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the whole dump is the header then each bank and window in index order.
    task automatic push_dump(input logic [31:0] hdr);
        sb.push_back('{hdr, 2'd0, 16'd0, 1'b0});
        for (int i = 0; i < NUM_GPR; i++) sb.push_back('{gpr[i], 2'd1, 16'(i), 1'b0});
`ifdef DUMP_FPR_EN
        for (int i = 0; i < NUM_FPR; i++) sb.push_back('{fpr[i], 2'd2, 16'(i), 1'b0});
`endif
        for (int i = 0; i < WORDS; i++)
            sb.push_back('{mem[i % 256], 2'd3, 16'(i), i == WORDS - 1});
    endtask

    // Main monitor: pops on every handshake, checks holds under stall and the done pulse.
    rec_t held, cur, exp_r;
    logic held_v = 1'b0, last_hs = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            held_v  = 1'b0;
            last_hs = 1'b0;
        end else begin
            chk("done_pulse", done, last_hs);
            if (done) n_done++;
`ifndef DUMP_FPR_EN
            chk("rf_sel_zero", rf_sel, 1'b0);
`endif
            cur = '{out_data, out_sec, out_idx, out_last};
            if (held_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_fields", cur, held);
            end
            held_v  = 1'b0;
            last_hs = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_record: got sec=%0d idx=%0d, none expected",
                                 out_sec, out_idx);
                    end else begin
                        exp_r = sb.pop_front();
                        if (cur !== exp_r) begin
                            errors++;
                            $display("FAIL record: got data=%0h sec=%0d idx=%0d last=%0b expected data=%0h sec=%0d idx=%0d last=%0b",
                                     cur.data, cur.sec, cur.idx, cur.last,
                                     exp_r.data, exp_r.sec, exp_r.idx, exp_r.last);
                        end
                    end
                    rec_n++;
                    last_hs = out_last;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end
        end
    end

    // Wrap-window monitor: memory records must read addresses 14,15,0,1 in that order.
    always @(negedge clk) begin
        if (rst) begin
            w_recs = 0;
            w_memk = 0;
        end else if (w_out_valid) begin
            w_recs++;
            if (w_out_sec == 2'd3) begin
                chk("wrap_idx", w_out_idx, 64'(w_memk));
                chk("wrap_data", w_out_data, 64'(32'h200 + ((14 + w_memk) % 16)));
                chk("wrap_last", w_out_last, 64'(w_memk == 3));
                w_memk++;
            end
        end
    end

    task automatic do_start(input bit with_w);
        start = 1'b1;
        start_w = with_w;
        push_dump(tb_cnt);
        @(posedge clk); #1;
        start = 1'b0;
        start_w = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("halt_req_after_start", halt_req, 1'b1);
    endtask

    // ready_mode: 0 held high, 1 toggling, 2 random.
    task automatic wait_done(input int target, input int base, input int ready_mode,
                             input bit rand_start, input bit rand_ack);
        for (int c = 0; c < 4000 && n_done == target; c++) begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (rand_ack) halt_ack = 1'($urandom_range(0, 1));
            start = (rand_start && busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (busy) chk("halt_req_held", halt_req, 1'b1);
        end
        start = 1'b0;
        halt_ack = 1'b1;
        out_ready = 1'b1;
        chk("dump_done", 64'(n_done), 64'(target + 1));
        chk("record_count", 64'(rec_n - base), 64'(TOTAL));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        chk("busy_idle", busy, 1'b0);
        chk("halt_req_idle", halt_req, 1'b0);
    endtask

    task automatic randomize_state();
        for (int i = 0; i < NUM_GPR; i++) gpr[i] = $urandom;
        for (int i = 0; i < NUM_FPR; i++) fpr[i] = $urandom;
        for (int i = 0; i < 256; i++)     mem[i] = $urandom;
    endtask

    initial begin
        int t, b;
        bit found;
        for (int i = 0; i < NUM_GPR; i++) gpr[i] = 32'(i);
        for (int i = 0; i < NUM_FPR; i++) fpr[i] = 32'h1000 + 32'(i);
        for (int i = 0; i < 256; i++)     mem[i] = 32'd100 + 32'(i);
        for (int i = 0; i < 16; i++)      wmem[i] = 32'h200 + 32'(i);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt_req", halt_req, 1'b0);
        chk("rst_rf_sel", rf_sel, 1'b0);
        chk("rst_rf_raddr", rf_raddr, 5'd0);
        chk("rst_mem_raddr", mem_raddr, 8'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sec", out_sec, 2'd0);
        chk("rst_out_idx", out_idx, 16'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        halt_ack = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Directed dump, full throughput, plus the wrapping memory window instance.
        t = n_done; b = rec_n;
        do_start(1'b1);
        wait_done(t, b, 0, 1'b0, 1'b0);
        chk("wrap_mem_records", 64'(w_memk), 64'd4);
        chk("wrap_total", 64'(w_recs), 64'(W_TOTAL));

        // Backpressure with ready toggling every cycle.
        t = n_done; b = rec_n;
        do_start(1'b0);
        wait_done(t, b, 1, 1'b0, 1'b0);

        // Delayed halt_ack: nothing emitted until two edges after it rises.
        randomize_state();
        halt_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        t = n_done; b = rec_n;
        do_start(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_valid_before_ack", out_valid, 1'b0);
        end
        halt_ack = 1'b1;
        @(posedge clk); #1;
        chk("hdr_not_yet", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("hdr_valid", out_valid, 1'b1);
        wait_done(t, b, 0, 1'b0, 1'b0);

        // Start pulses while busy, random ready and a wobbling halt_ack.
        randomize_state();
        t = n_done; b = rec_n;
        do_start(1'b0);
        wait_done(t, b, 2, 1'b1, 1'b1);

        // Reset in the middle of the GPR section, then a fresh complete dump.
        t = n_done;
        do_start(1'b0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            found = out_valid && out_sec == 2'd1 && out_idx == 16'd5;
        end
        chk("reached_gpr5", found, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_halt_req", halt_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_no_done", 64'(n_done), 64'(t));
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        randomize_state();
        t = n_done; b = rec_n;
        do_start(1'b0);
        wait_done(t, b, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
